// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO register pair and multiply/divide engine.
package hilo_pkg;

    // md_op encodings
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    // Divide ops have bit 1 set
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have bit 0 clear
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per clock.
// A start reloads the operands regardless of any operation still in progress,
// so an abandoned divide never needs to be cancelled explicitly.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (start) begin
            cnt_d = CW'(WIDTH);
            quo_d = a;
            rem_d = '0;
            dvs_d = b;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            // trial[WIDTH] is the borrow: set when the divisor did not fit
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CW'(1));
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO architectural registers with N-stage read forwarding, plus a
// multi-cycle multiply (pipelined) and divide (iterative) engine.
// Handshake: md_start is accepted only while md_busy is low and md_flush is
// low; the result is valid in the single cycle md_done is high and stays on
// md_hi/md_lo until the next accepted start completes.
module hilo_md_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_FWD   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hilo_we,
    input  logic [WIDTH-1:0]       hi_wdata,
    input  logic [WIDTH-1:0]       lo_wdata,
    input  logic [N_FWD-1:0]       fwd_we,
    input  logic [N_FWD*WIDTH-1:0] fwd_hi,
    input  logic [N_FWD*WIDTH-1:0] fwd_lo,
    output logic [WIDTH-1:0]       hi_rdata,
    output logic [WIDTH-1:0]       lo_rdata,
    input  logic                   md_start,
    input  logic [1:0]             md_op,
    input  logic [WIDTH-1:0]       md_a,
    input  logic [WIDTH-1:0]       md_b,
    input  logic                   md_flush,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [WIDTH-1:0]       md_hi,
    output logic [WIDTH-1:0]       md_lo,
    output logic [1:0]             dbg_state
);

    localparam int MCW = $clog2(MUL_LAT + 1);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] md_hi_q, md_hi_d, md_lo_q, md_lo_d;
    logic             done_q, done_d;
    logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;

    logic [2*WIDTH-1:0] mul_pipe_q [MUL_LAT];
    logic [2*WIDTH-1:0] mul_pipe_d [MUL_LAT];
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    logic             accept, accept_mul, div_start;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    logic             div_busy, div_last;
    logic [WIDTH-1:0] div_q, div_r;

    // Read path: youngest in-flight writer wins, then the retiring commit, then the registers
    always_comb begin
        hi_rdata = hilo_we ? hi_wdata : hi_q;
        lo_rdata = hilo_we ? lo_wdata : lo_q;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i]) begin
                hi_rdata = fwd_hi[i*WIDTH +: WIDTH];
                lo_rdata = fwd_lo[i*WIDTH +: WIDTH];
            end
        end
    end

    // Architectural HI/LO are written only by the commit port
    always_comb begin
        hi_d = hilo_we ? hi_wdata : hi_q;
        lo_d = hilo_we ? lo_wdata : lo_q;
    end

    // Product of sign- or zero-extended operands; the low 2*WIDTH bits are exact either way
    always_comb begin
        ext_a   = op_is_signed(md_op) ? {{WIDTH{md_a[WIDTH-1]}}, md_a} : {{WIDTH{1'b0}}, md_a};
        ext_b   = op_is_signed(md_op) ? {{WIDTH{md_b[WIDTH-1]}}, md_b} : {{WIDTH{1'b0}}, md_b};
        product = ext_a * ext_b;
    end

    // Multiply pipe: stage 0 captures at acceptance, later stages shift every clock
    always_comb begin
        mul_pipe_d[0] = accept_mul ? product : mul_pipe_q[0];
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end
    end

    // Operand magnitudes and sign bookkeeping for the divider
    always_comb begin
        a_neg     = op_is_signed(md_op) & md_a[WIDTH-1];
        b_neg     = op_is_signed(md_op) & md_b[WIDTH-1];
        mag_a     = a_neg ? -md_a : md_a;
        mag_b     = b_neg ? -md_b : md_b;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        a_orig_d  = a_orig_q;
        if (div_start) begin
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            bzero_d   = (md_b == '0);
            a_orig_d  = md_a;
        end
        // Negating 0x80..0 yields itself, which gives the required overflow wrap
        fix_quo = neg_quo_q ? -div_q : div_q;
        fix_rem = neg_rem_q ? -div_r : div_r;
    end

    // Control FSM: acceptance, completion, flush and result capture
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        md_hi_d    = md_hi_q;
        md_lo_d    = md_lo_q;
        mul_cnt_d  = mul_cnt_q;
        accept     = 1'b0;
        accept_mul = 1'b0;
        div_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md_start && !md_flush) begin
                    accept     = 1'b1;
                    accept_mul = !op_is_div(md_op);
                    div_start  = op_is_div(md_op);
                    mul_cnt_d  = '0;
                    state_d    = op_is_div(md_op) ? DIV : MUL;
                end
            end
            MUL: begin
                if (md_flush) begin
                    state_d = IDLE;
                end else if (mul_cnt_q == MCW'(MUL_LAT - 1)) begin
                    md_hi_d = mul_pipe_q[MUL_LAT-1][2*WIDTH-1:WIDTH];
                    md_lo_d = mul_pipe_q[MUL_LAT-1][WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            DIV: begin
                if (md_flush) begin
                    state_d = IDLE;
                end else if (div_busy && div_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (md_flush) begin
                    state_d = IDLE;
                end else begin
                    md_lo_d = bzero_q ? {WIDTH{1'b1}} : fix_quo;
                    md_hi_d = bzero_q ? a_orig_q : fix_rem;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All unit state; asynchronous reset returns everything to idle and zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            md_hi_q   <= '0;
            md_lo_q   <= '0;
            done_q    <= 1'b0;
            mul_cnt_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            a_orig_q  <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            md_hi_q   <= md_hi_d;
            md_lo_q   <= md_lo_d;
            done_q    <= done_d;
            mul_cnt_q <= mul_cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            a_orig_q  <= a_orig_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe_q[i] <= mul_pipe_d[i];
            end
        end
    end

    md_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (mag_a),
        .b     (mag_b),
        .busy  (div_busy),
        .last  (div_last),
        .q     (div_q),
        .r     (div_r)
    );

    assign md_busy   = (state_q != IDLE);
    assign md_done   = done_q;
    assign md_hi     = md_hi_q;
    assign md_lo     = md_lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Bench for hilo_md_unit: arithmetic reference model, per-cycle compare, directed vectors.
module tb_hilo_md_unit;

    localparam int W  = 32;
    localparam int NF = 2;
    localparam int ML = 2;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              hilo_we;
    logic [W-1:0]      hi_wdata, lo_wdata;
    logic [NF-1:0]     fwd_we;
    logic [NF*W-1:0]   fwd_hi, fwd_lo;
    logic [W-1:0]      hi_rdata, lo_rdata;
    logic              md_start, md_flush;
    logic [1:0]        md_op;
    logic [W-1:0]      md_a, md_b;
    logic              md_busy, md_done;
    logic [W-1:0]      md_hi, md_lo;
    logic [1:0]        dbg_state;

    hilo_md_unit #(.WIDTH(W), .N_FWD(NF), .MUL_LAT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .hilo_we   (hilo_we),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata),
        .fwd_we    (fwd_we),
        .fwd_hi    (fwd_hi),
        .fwd_lo    (fwd_lo),
        .hi_rdata  (hi_rdata),
        .lo_rdata  (lo_rdata),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_flush  (md_flush),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_hi     (md_hi),
        .md_lo     (md_lo),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}
    function automatic logic [2*W-1:0] md_model(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint sa, sb, qq, rr;
        logic [2*W-1:0] res;
        logic [2*W-1:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        res = '0;
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else begin
                    qq  = sa / sb;
                    rr  = sa % sb;
                    res = {rr[W-1:0], qq[W-1:0]};
                end
            end
            default: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Behavioural model of the engine timing and HI/LO registers
    logic         m_busy, m_done;
    logic [W-1:0] m_hi, m_lo, m_hq, m_lq;
    logic [2*W-1:0] m_pend;
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
            m_hq = '0; m_lq = '0; m_cnt = 0; m_pend = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (md_flush) m_busy = 1'b0;
                else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        {m_hi, m_lo} = m_pend;
                        m_done = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end else if (md_start && !md_flush) begin
                m_pend = md_model(md_op, md_a, md_b);
                m_busy = 1'b1;
                m_cnt  = md_op[1] ? (W + 1) : ML;
            end
            if (hilo_we) begin
                m_hq = hi_wdata;
                m_lq = lo_wdata;
            end
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge clk) begin
        logic [W-1:0] eh, el;
        logic found;
        eh = hilo_we ? hi_wdata : m_hq;
        el = hilo_we ? lo_wdata : m_lq;
        found = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (!found && fwd_we[i]) begin
                eh = fwd_hi[i*W +: W];
                el = fwd_lo[i*W +: W];
                found = 1'b1;
            end
        end
        chk("hi_rdata", hi_rdata, eh);
        chk("lo_rdata", lo_rdata, el);
        chk("md_busy", md_busy, m_busy);
        chk("md_done", md_done, m_done);
        chk("md_hi", md_hi, m_hi);
        chk("md_lo", md_lo, m_lo);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        md_op = op; md_a = a; md_b = b; md_start = 1'b1;
        step();
        md_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        n = 0;
        while (!md_done && n < 100) begin
            step();
            n++;
        end
        chk({name, " latency"}, n, exp_lat);
        chk({name, " hi"}, md_hi, ehi);
        chk({name, " lo"}, md_lo, elo);
    endtask

    initial begin
        rst = 1'b1; hilo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
        fwd_we = '0; fwd_hi = '0; fwd_lo = '0;
        md_start = 1'b0; md_flush = 1'b0; md_op = 2'b00; md_a = '0; md_b = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset md_hi", md_hi, 0);
        chk("reset md_lo", md_lo, 0);
        chk("reset busy", md_busy, 0);
        chk("reset done", md_done, 0);
        chk("reset hi_rdata", hi_rdata, 0);

        // Forwarding priority
        hilo_we = 1'b1; hi_wdata = 32'h11; lo_wdata = 32'h22;
        step();
        hilo_we = 1'b0;
        fwd_hi = {32'hBB, 32'hAA}; fwd_lo = {32'hDD, 32'hCC};
        fwd_we = 2'b11; #1;
        chk("fwd11 hi", hi_rdata, 32'hAA);
        chk("fwd11 lo", lo_rdata, 32'hCC);
        step();
        fwd_we = 2'b10; #1;
        chk("fwd10 hi", hi_rdata, 32'hBB);
        step();
        fwd_we = 2'b00; #1;
        chk("fwd00 hi", hi_rdata, 32'h11);
        chk("fwd00 lo", lo_rdata, 32'h22);
        step();
        hilo_we = 1'b1; hi_wdata = 32'h55; lo_wdata = 32'h66; #1;
        chk("commit bypass hi", hi_rdata, 32'h55);
        step();
        hilo_we = 1'b0;

        // Multiplies
        issue(2'b00, 32'hFFFFFFFF, 32'h2);
        chk("mult busy E0", md_busy, 1);
        wait_done("mult", 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue(2'b01, 32'hFFFFFFFF, 32'h2);
        wait_done("multu", 2, 32'h1, 32'hFFFFFFFE);
        issue(2'b00, 32'h80000000, 32'h80000000);
        wait_done("mult minmin", 2, 32'h40000000, 32'h0);

        // Divides
        issue(2'b10, 32'hFFFFFFF9, 32'h2);
        chk("div busy E0", md_busy, 1);
        wait_done("div -7/2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(2'b11, 32'h5, 32'h0);
        wait_done("divu 5/0", 33, 32'h5, 32'hFFFFFFFF);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div ovf", 33, 32'h0, 32'h80000000);
        issue(2'b10, 32'hFFFFFFF9, 32'h0);
        wait_done("div -7/0", 33, 32'hFFFFFFF9, 32'hFFFFFFFF);
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu 100/7", 33, 32'd2, 32'd14);
        issue(2'b10, 32'd7, 32'hFFFFFFFE);
        wait_done("div 7/-2", 33, 32'd1, 32'hFFFFFFFD);
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        wait_done("mult -3*5", 2, 32'hFFFFFFFF, 32'hFFFFFFF1);

        // Flush during divide at E10
        issue(2'b10, 32'd100, 32'd3);
        repeat (9) step();
        md_flush = 1'b1;
        step();
        md_flush = 1'b0;
        chk("flush busy", md_busy, 0);
        chk("flush lo kept", md_lo, 32'hFFFFFFF1);
        repeat (5) step();
        issue(2'b11, 32'd100, 32'd7);
        wait_done("after flush", 33, 32'd2, 32'd14);

        // Start while busy is ignored
        issue(2'b00, 32'd3, 32'd4);
        md_op = 2'b11; md_a = 32'd1; md_b = 32'd1; md_start = 1'b1;
        step();
        md_start = 1'b0;
        wait_done("busy ignore", 1, 32'd0, 32'd12);

        // Flush with start in idle drops the start
        md_op = 2'b00; md_a = 32'd9; md_b = 32'd9; md_start = 1'b1; md_flush = 1'b1;
        step();
        md_start = 1'b0; md_flush = 1'b0;
        chk("flush+start busy", md_busy, 0);
        step();

        // Back-to-back start in the done cycle
        issue(2'b01, 32'd6, 32'd7);
        wait_done("b2b first", 2, 32'd0, 32'd42);
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("b2b second", 2, 32'd0, 32'd1);

        // Asynchronous reset mid-multiply
        issue(2'b00, 32'd9, 32'd9);
        rst = 1'b1; #1;
        chk("rst md_hi", md_hi, 0);
        chk("rst md_lo", md_lo, 0);
        chk("rst busy", md_busy, 0);
        chk("rst done", md_done, 0);
        chk("rst hi_rdata", hi_rdata, 0);
        #1;
        rst = 1'b0;
        repeat (4) step();
        chk("rst no done", md_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
